// File: rtl/jls_bit_packer.sv
// ----------------------------------------------------------------------------
// jls_bit_packer
//   Output stage of the LOCO-I / JPEG-LS encoder. Takes one right-aligned
//   variable-length code per cycle (0..32 bits), concatenates codes MSB-first
//   in a bit accumulator, extracts at most one byte per cycle, gathers bytes
//   into OUT_W-bit words and presents them on a valid/ready output with
//   flush / end-of-segment signalling.
//
// Optional feature macro: JLS_FF_STUFF_EN
//   defined   : after every emitted 0xFF the next byte carries a leading 0
//               stuffing bit; a segment ending in 0xFF gets a trailing 0x00.
//   undefined : plain byte packing, no FF-history register.
//
// Parameters
//   OUT_W  output word width (8, 16 or 32)
//   ACC_W  bit-accumulator width (>= 64)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   en           input code valid
//   cod_32       code, right-aligned in the low len_32 bits
//   len_32       code length 0..32 (larger values saturate to 32)
//   flush        end-of-segment request (may coincide with en)
//   in_ready     en/flush accepted when high
//   word_out     packed word, first stream bit at MSB
//   word_valid   word_out holds a word
//   word_ready   consumer accepts word_out
//   word_last    final word of a flushed segment
//   word_bytes   valid bytes in word_out, MSB-aligned
//   flush_done   one-cycle pulse when a flush completes
// ----------------------------------------------------------------------------
module jls_bit_packer #(
    parameter int OUT_W = 32,
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [31:0]      cod_32,
    input  logic [5:0]       len_32,
    input  logic             flush,
    output logic             in_ready,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic [2:0]       word_bytes,
    output logic             flush_done
);

    localparam int              NB      = OUT_W / 8;
    localparam int              FW      = $clog2(ACC_W + 1);
    localparam logic [2:0]      NB_L    = 3'(NB);
    localparam logic [2:0]      LASTB   = 3'(NB - 1);
    localparam logic [FW-1:0]   RDY_LIM = FW'(ACC_W - 32);
    localparam logic [FW:0]     ACC_L   = (FW + 1)'(ACC_W);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PAD, S_TAIL} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;      // MSB-aligned, bits below r_fill kept zero
    logic [FW-1:0]    r_fill;
    logic [OUT_W-1:0] r_gath;     // right-aligned partial word
    logic [2:0]       r_gcnt;
    logic [OUT_W-1:0] r_word;
    logic             r_wvalid;
    logic             r_wlast;
    logic [2:0]       r_wbytes;
    logic             r_fdone;

    logic             w_ff;
`ifdef JLS_FF_STUFF_EN
    logic             r_ff;       // previously emitted byte was 0xFF
    assign w_ff = r_ff;
`else
    assign w_ff = 1'b0;
`endif

    logic [FW-1:0]    w_need;
    logic [5:0]       w_len;
    logic             w_accept;
    logic             w_flush_acc;
    logic [31:0]      w_code;
    logic [ACC_W-1:0] w_code_ext;
    logic [FW-1:0]    w_len_f;
    logic [FW-1:0]    w_shamt;
    logic [FW-1:0]    w_fill_x;
    logic [FW:0]      w_pos;
    logic [ACC_W-1:0] w_acc_nx;
    logic [FW-1:0]    w_fill_nx;
    logic             w_fill_ge;
    logic             w_out_free;
    logic             w_gath_ok;
    logic [7:0]       w_byte;
    logic [OUT_W-1:0] w_gnext;
    logic [5:0]       w_tail_sh;
    logic [OUT_W-1:0] w_tail_word;

    logic             w_extract;
    logic             w_emit;
    logic             w_pad_res;
    logic [7:0]       w_emit_byte;

    assign in_ready    = reset && (r_state == S_RUN) && (r_fill <= RDY_LIM);
    assign w_accept    = en & in_ready;
    assign w_flush_acc = flush & in_ready;

    assign w_need      = w_ff ? FW'(7) : FW'(8);
    assign w_len       = (len_32 > 6'd32) ? 6'd32 : len_32;
    // Shift by 32 yields zero, so len=32 keeps every bit.
    assign w_code      = w_accept ? (cod_32 & ~(32'hFFFF_FFFF << w_len)) : 32'd0;
    assign w_code_ext  = {{(ACC_W-32){1'b0}}, w_code};
    assign w_len_f     = w_accept ? FW'(w_len) : '0;

    // Extraction first, then the new code lands right below the survivors.
    assign w_shamt     = w_extract ? w_need : '0;
    assign w_fill_x    = r_fill - w_shamt;
    assign w_pos       = ACC_L - {1'b0, w_fill_x} - {1'b0, w_len_f};
    assign w_acc_nx    = (r_acc << w_shamt) | (w_code_ext << w_pos);
    assign w_fill_nx   = w_fill_x + w_len_f;

    assign w_fill_ge   = (r_fill >= w_need);
    assign w_out_free  = !r_wvalid || word_ready;
    // The word-completing byte needs room in the output register.
    assign w_gath_ok   = (r_gcnt != LASTB) || w_out_free;

    // After 0xFF the stuffed byte carries a 0 MSB and only 7 stream bits.
    assign w_byte      = w_ff ? {1'b0, r_acc[ACC_W-1 -: 7]} : r_acc[ACC_W-1 -: 8];
    assign w_gnext     = (r_gath << 8) | OUT_W'(w_emit_byte);
    assign w_tail_sh   = {NB_L - r_gcnt, 3'b000};
    assign w_tail_word = r_gath << w_tail_sh;

    always_comb begin
        w_extract   = 1'b0;
        w_emit      = 1'b0;
        w_pad_res   = 1'b0;
        w_emit_byte = w_byte;
        case (r_state)
            S_RUN, S_DRAIN: w_extract = w_fill_ge && w_gath_ok;
            S_PAD: begin
                if (r_fill != '0) begin
                    // residual bits, zero-padded at the LSBs
                    w_emit    = w_gath_ok;
                    w_pad_res = w_gath_ok;
                end else if (w_ff) begin
                    w_emit      = w_gath_ok;
                    w_emit_byte = 8'h00;
                end
            end
            default: ;
        endcase
        if (w_extract) w_emit = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_acc    <= '0;
            r_fill   <= '0;
            r_gath   <= '0;
            r_gcnt   <= '0;
            r_word   <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_wbytes <= '0;
            r_fdone  <= 1'b0;
`ifdef JLS_FF_STUFF_EN
            r_ff     <= 1'b0;
`endif
        end else begin
            r_fdone <= 1'b0;

            if (w_pad_res) begin
                r_acc  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_acc_nx;
                r_fill <= w_fill_nx;
            end

`ifdef JLS_FF_STUFF_EN
            if (w_emit) r_ff <= (w_emit_byte == 8'hFF);
`endif

            if (r_wvalid && word_ready) r_wvalid <= 1'b0;

            if (w_emit) begin
                if (r_gcnt == LASTB) begin
                    r_word   <= w_gnext;
                    r_wvalid <= 1'b1;
                    r_wbytes <= NB_L;
                    r_wlast  <= 1'b0;
                    r_gath   <= '0;
                    r_gcnt   <= '0;
                end else begin
                    r_gath   <= w_gnext;
                    r_gcnt   <= r_gcnt + 3'd1;
                end
            end

            case (r_state)
                S_RUN:   if (w_flush_acc) r_state <= S_DRAIN;
                S_DRAIN: if (!w_fill_ge) r_state <= S_PAD;
                S_PAD:   if (r_fill == '0 && !w_ff) r_state <= S_TAIL;
                S_TAIL: begin
                    if (r_gcnt != '0) begin
                        if (w_out_free) begin
                            r_word   <= w_tail_word;
                            r_wvalid <= 1'b1;
                            r_wbytes <= r_gcnt;
                            r_wlast  <= 1'b1;
                            r_gath   <= '0;
                            r_gcnt   <= '0;
                            r_fdone  <= 1'b1;
                            r_state  <= S_RUN;
`ifdef JLS_FF_STUFF_EN
                            r_ff     <= 1'b0;
`endif
                        end
                    end else begin
                        // only a still-pending word can be tagged as last
                        if (r_wvalid && !word_ready) r_wlast <= 1'b1;
                        r_fdone <= 1'b1;
                        r_state <= S_RUN;
`ifdef JLS_FF_STUFF_EN
                        r_ff    <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_wvalid;
    assign word_last  = r_wlast;
    assign word_bytes = r_wbytes;
    assign flush_done = r_fdone;

endmodule

// File: doc/jls_bit_packer.md
# jls_bit_packer

- Parametrised output stage of the LOCO-I/JPEG-LS encoder.
- Accepts one variable-length code per cycle (right-aligned, 0–32 bits, the same form as the code-stream stage's `cod_32`/`len_32` output) and concatenates codes MSB-first.
- Optionally applies JPEG-LS 0xFF bit stuffing, and emits fixed-width output words with backpressure, flush and end-of-segment flags.
- Sits between the code-stream stage and the memory/stream writer; supersedes fixed 32-bit code output with arbitrary-width byte-aligned packing.

## Interface
Parameters:
- `OUT_W`, 32, output word width in bits. Legal values: 8, 16 or 32.
- `ACC_W`, 64, bit-accumulator width. Must be ≥ 2×32.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  input code valid.
- `cod_32`  in  32  code, right-aligned in the low `len_32` bits; upper bits ignored.
- `len_32`  in  6  code length, 0–32. Values above 32 saturate to 32.
- `flush`  in  1  end-of-segment request. May coincide with `en`.
- `in_ready`  out  1  `en`/`flush` are accepted on a cycle where `in_ready` is 1.
- `word_out`  out  OUT_W  packed word; first bit of the stream is at the MSB.
- `word_valid`  out  1  `word_out` holds a word.
- `word_ready`  in  1  consumer accepts the word when `word_valid && word_ready`.
- `word_last`  out  1  final word of a flushed segment.
- `word_bytes`  out  3  number of valid bytes in `word_out` (1..OUT_W/8), MSB-aligned.
- `flush_done`  out  1  one-cycle pulse when flush completes.

## Operation
- Accumulator `acc` holds `fill` bits, MSB-aligned.
- Accept: a new code is appended below the existing bits, so `fill += len`.
- `in_ready = (fill ≤ ACC_W−32) && state==RUN`. A code with `len_32`=0 is accepted with no effect.
- Byte extraction, at most one byte per cycle:
  - `need` = 7 if the previously emitted byte was 0xFF and stuffing is enabled; otherwise 8.
  - The extract condition is `fill ≥ need` and the gatherer can take the byte.
  - The emitted byte is the top 8 bits, or `{1'b0, top 7 bits}` when `need` = 7.
  - `fill` decreases by `need`.
  - An accept and an extraction in the same cycle are combined: `fill' = fill + len − need`.
- Gatherer:
  - Shifts bytes in MSB-first.
  - On the OUT_W/8-th byte, the word moves to the output register.
  - The gatherer can take the completing byte only if the output register is empty or is being consumed this cycle; otherwise extraction stalls.
- Output register holds `word_out`/`word_bytes`/`word_last` stable while `word_valid && !word_ready`.
- FSM:
  - RUN: normal operation. An accepted `flush` (with its same-cycle code, if any) moves the FSM to DRAIN.
  - DRAIN: extract until `fill < need`, then go to PAD.
  - PAD: handle the residual bits, in order:
    - If 0 < `fill`, emit one byte of the residual bits padded with 0 at the LSBs.
    - If stuffing is enabled and the last emitted byte was 0xFF, emit 0x00 as well.
    - Then go to TAIL.
  - TAIL: handle the partial word, then pulse `flush_done` and return to RUN.
    - If the gatherer holds k>0 bytes, push the word with its low bytes zero-filled, `word_bytes=k`, `word_last=1`, once the output register is free.
    - If the gatherer is empty, mark the word already in the output register (if it is unconsumed) `word_last=1`. If none is pending, emit nothing.
  - After a flush the "previous byte 0xFF" history is cleared.
- Full words set `word_bytes=OUT_W/8`, `word_last=0`.

## Timing
- Reset (asynchronous assert, synchronous-release use): the following are cleared.
  - `fill`, gatherer and FF history = 0; FSM in RUN.
  - `word_out`=0, `word_valid`=0, `word_last`=0, `word_bytes`=0, `flush_done`=0.
  - `in_ready` is 0 while `reset` is low and 1 in the first cycle after release.
- Reset mid-operation discards all buffered bits and any pending word, with no partial output.
- Latency: with the block empty and no backpressure, a code of ≥OUT_W bits accepted on edge E0 raises `word_valid` after edge E0+OUT_W/8.
- Sustained throughput is one byte per cycle. `in_ready` throttles input above that rate.
- `word_valid` never drops without a handshake.
- `flush_done` is high for exactly one cycle, the cycle after TAIL completes.

## Configuration
- `JLS_FF_STUFF_EN` defined:
  - After every emitted 0xFF, the next byte carries a leading 0 stuffing bit.
  - A segment ending in 0xFF gets a trailing 0x00.
- Undefined: `need` is always 8, with no stuffing and no trailing byte. The FF-history register is removed.

## Test plan
- OUT_W=32, no stall: `cod_32`=0xABCD/len 16, then 0x1234/len 16 → one word 0xABCD1234, `word_bytes`=4, `word_last`=0, `word_valid` at E0+4.
- Stuffing on, OUT_W=16: 0xFF/len 8, 0x7F/len 7, then flush → word 0xFF7F, `word_bytes`=2, `word_last`=1, `flush_done` pulse. With the macro off, the same stimulus gives 0xFFFE, `word_bytes`=2.
- OUT_W=32: 0b101/len 3, then flush → word 0xA0000000, `word_bytes`=1, `word_last`=1.
- Stuffing on, OUT_W=32: 0xFF/len 8, then flush → 0xFF000000, `word_bytes`=2, `word_last`=1.
- Backpressure: 8 codes of 0xFFFFFFFF/len 32 with stuffing off, `word_ready` held 0 for 20 cycles.
  - `in_ready` falls once `fill` > 32 and the output is held stable.
  - On release, eight 0xFFFFFFFF words arrive with none lost.
- Reset low mid-stream with 20 bits buffered → all outputs 0 immediately. After release, 0x5A/len 8 plus flush → 0x5A000000, `word_bytes`=1.
